// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite bus bundle between a master (or bridge) and the word-addressed memory slave.
// HREADY is the bus-level ready returned by the interconnect; in a single-slave
// system it is simply HREADYOUT looped back.
interface ahb_slave_mem_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: word-addressed RAM with programmable data-phase wait
// states and a two-cycle ERROR response for out-of-range, misaligned or
// unsupported-size transfers. HBURST is accepted on the bus but not decoded.
module ahb_slave_mem #(
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic           HCLK,
    input  logic           HRESET,
    ahb_slave_mem_if.slave bus
);

    localparam int          IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [32:0] SPAN      = 33'(MEM_DEPTH) << 2;
    localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               ready_out, resp_out;

    // Data-phase copy of the accepted address phase
    logic               pend_q;
    logic               write_q;
    logic [1:0]         size_q;
    logic [1:0]         lane_q;
    logic [IDX_W-1:0]   idx_q;

    logic [31:0]        rdata_q;
    logic [31:0]        rdata_out;
    logic [31:0]        mem [MEM_DEPTH];

    logic [32:0]        diff;
    logic               in_range;
    logic               misaligned;
    logic               addr_err;
    logic               open_slot;
    logic               accept;
    logic               mem_we;
    logic               read_done;
    logic [3:0]         lane_en;
    logic [31:0]        rd_word;

    // A borrow out of the 33-bit subtraction makes diff huge, so one compare
    // covers both the below-base and the beyond-top cases.
    assign diff       = {1'b0, bus.HADDR} - {1'b0, BASE_ADDR};
    assign in_range   = (diff < SPAN);
    assign misaligned = ((bus.HSIZE == 3'd1) && bus.HADDR[0]) ||
                        ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00));
    assign addr_err   = !in_range || (bus.HSIZE > 3'd2) || misaligned;

    // A new address phase can only be taken while the slave is showing ready
    assign open_slot  = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign accept     = bus.HSEL && bus.HREADY && bus.HTRANS[1] && open_slot;

    // An OKAY transfer completes in IDLE; WAIT merely stretches it
    assign mem_we     = pend_q && write_q && (state_q == ST_IDLE);
    assign read_done  = pend_q && !write_q && (state_q == ST_IDLE);
    assign rd_word    = mem[idx_q];

    // State register and wait counter
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and handshake outputs; ERR2 honours a new accept exactly as IDLE does
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_out = 1'b1;
        resp_out  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (state_q == ST_ERR2) begin
                    resp_out = 1'b1;
                    state_d  = ST_IDLE;
                end
                if (accept) begin
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT: begin
                ready_out = 1'b0;
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: begin
                ready_out = 1'b0;
                resp_out  = 1'b1;
                state_d   = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture the address phase on accept; an erroring transfer never becomes pending
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pend_q  <= 1'b0;
            write_q <= 1'b0;
            size_q  <= 2'd0;
            lane_q  <= 2'd0;
            idx_q   <= '0;
        end else if (accept) begin
            pend_q  <= !addr_err;
            write_q <= bus.HWRITE;
            size_q  <= bus.HSIZE[1:0];
            lane_q  <= bus.HADDR[1:0];
            idx_q   <= diff[IDX_W+1:2];
        end else if (open_slot) begin
            pend_q  <= 1'b0;
        end
    end

    // Byte-lane enables from the registered size and low address bits
    always_comb begin
        lane_en = 4'b0000;
        case (size_q)
            2'd0:    lane_en[lane_q] = 1'b1;
            2'd1:    lane_en = lane_q[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    end

    // Memory array is never reset; only completing OKAY writes touch it
    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) begin
                    mem[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Remember the last value shown on HRDATA so it holds outside read data phases
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rdata_q <= 32'd0;
        end else if (read_done) begin
            rdata_q <= rd_word;
        end else if (state_q == ST_ERR1) begin
            rdata_q <= 32'd0;
        end
    end

    // Read data comes straight from the array so a write on the previous edge is visible
    always_comb begin
        if ((state_q == ST_ERR1) || (state_q == ST_ERR2)) begin
            rdata_out = 32'd0;
        end else if (read_done) begin
            rdata_out = rd_word;
        end else begin
            rdata_out = rdata_q;
        end
    end

    assign bus.HREADYOUT = ready_out;
    assign bus.HRESP     = resp_out;
    assign bus.HRDATA    = rdata_out;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Scoreboard bench for ahb_slave_mem: one instance with no wait states and one
// with three, each driven by its own pipelined AHB master process. Expected
// responses come from a byte-array model and are checked by a negedge monitor.
module tb_ahb_slave_mem;

    localparam int MEM_DEPTH = 1024;
    localparam int WIN_BYTES = 128;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    typedef struct {
        bit          is_read;
        bit          err;
        logic [31:0] data;
        int          waits;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [2];
    logic        d_sel   [2];
    logic [31:0] d_addr  [2];
    logic        d_write [2];
    logic [2:0]  d_size  [2];
    logic [2:0]  d_burst [2];
    logic [1:0]  d_trans [2];
    logic [31:0] d_wdata [2];
    logic        o_ready [2];
    logic        o_resp  [2];
    logic [31:0] o_rdata [2];

    ahb_slave_mem_if bus0 ();
    ahb_slave_mem_if bus1 ();

    assign bus0.HSEL   = d_sel[0];
    assign bus0.HADDR  = d_addr[0];
    assign bus0.HWRITE = d_write[0];
    assign bus0.HSIZE  = d_size[0];
    assign bus0.HBURST = d_burst[0];
    assign bus0.HTRANS = d_trans[0];
    assign bus0.HWDATA = d_wdata[0];
    assign bus0.HREADY = bus0.HREADYOUT;
    assign o_ready[0]  = bus0.HREADYOUT;
    assign o_resp[0]   = bus0.HRESP;
    assign o_rdata[0]  = bus0.HRDATA;

    assign bus1.HSEL   = d_sel[1];
    assign bus1.HADDR  = d_addr[1];
    assign bus1.HWRITE = d_write[1];
    assign bus1.HSIZE  = d_size[1];
    assign bus1.HBURST = d_burst[1];
    assign bus1.HTRANS = d_trans[1];
    assign bus1.HWDATA = d_wdata[1];
    assign bus1.HREADY = bus1.HREADYOUT;
    assign o_ready[1]  = bus1.HREADYOUT;
    assign o_resp[1]   = bus1.HRESP;
    assign o_rdata[1]  = bus1.HRDATA;

    ahb_slave_mem #(.MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(rst[0]), .bus(bus0)
    );
    ahb_slave_mem #(.MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut1 (
        .HCLK(clk), .HRESET(rst[1]), .bus(bus1)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ws [2] = '{0, 3};
    int   last_done_cyc [2] = '{0, 0};
    bit   in_dp [2] = '{0, 0};
    int   waits [2] = '{0, 0};
    exp_t exp_q0 [$];
    exp_t exp_q1 [$];
    exp_t mon_e;
    logic [7:0] model_mem [2][WIN_BYTES];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check_output(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void note_fail(string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s (t=%0t)", name, $time);
    endfunction

    function automatic int q_size(int w);
        return (w == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic void q_push(int w, exp_t e);
        if (w == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endfunction

    function automatic exp_t q_pop(int w);
        return (w == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    endfunction

    function automatic exp_t q_peek(int w);
        return (w == 0) ? exp_q0[0] : exp_q1[0];
    endfunction

    // Reference model: byte-addressed memory, transfers legal only if in range and naturally aligned
    function automatic exp_t predict(int w, bit wr, logic [2:0] size, logic [31:0] addr, logic [31:0] wdata);
        exp_t e;
        int   nbytes;
        int   a;
        int   base;
        e.is_read = !wr;
        e.err     = 1'b0;
        e.data    = 32'd0;
        e.waits   = ws[w];
        if (size > 3'd2) begin
            e.err = 1'b1;
        end else begin
            nbytes = 1 << size;
            if (addr >= 32'(4 * MEM_DEPTH)) e.err = 1'b1;
            else if ((int'(addr[1:0]) % nbytes) != 0) e.err = 1'b1;
        end
        if (e.err) begin
            e.waits = 1;
        end else if (wr) begin
            for (int k = 0; k < nbytes; k++) begin
                a = int'(addr) + k;
                model_mem[w][a] = wdata[8*(a%4) +: 8];
            end
        end else begin
            base   = int'(addr) & ~3;
            e.data = {model_mem[w][base+3], model_mem[w][base+2], model_mem[w][base+1], model_mem[w][base]};
        end
        return e;
    endfunction

    // Hold the address phase until the slave accepts it; returns just after that edge
    task automatic wait_accept(int w, output bit ok);
        bit r;
        int n;
        n  = 0;
        ok = 1'b0;
        forever begin
            @(negedge clk);
            r = o_ready[w];
            @(posedge clk);
            n++;
            if (r) begin
                ok = 1'b1;
                break;
            end
            if (n > 64) begin
                note_fail($sformatf("accept_timeout dut%0d", w));
                break;
            end
        end
        #1;
    endtask

    task automatic apply_stimulus(int w, bit sel, logic [1:0] trans, bit wr, logic [2:0] size,
                                  logic [31:0] addr, logic [31:0] wdata, logic [2:0] burst);
        bit   ok;
        exp_t e;
        d_sel[w]   = sel;
        d_trans[w] = trans;
        d_write[w] = wr;
        d_size[w]  = size;
        d_addr[w]  = addr;
        d_burst[w] = burst;
        wait_accept(w, ok);
        if (ok && sel && trans[1]) begin
            e = predict(w, wr, size, addr, wdata);
            q_push(w, e);
            d_wdata[w] = wdata;
        end
    endtask

    task automatic set_idle(int w);
        d_sel[w]   = 1'b0;
        d_trans[w] = T_IDLE;
    endtask

    task automatic wait_drain(int w);
        int n;
        n = 0;
        while ((q_size(w) > 0) && (n < 400)) begin
            @(posedge clk);
            n++;
        end
        if (q_size(w) > 0) note_fail($sformatf("drain_timeout dut%0d", w));
        #1;
    endtask

    // Monitor: compares each completed data phase against the head of the scoreboard
    always @(negedge clk) begin
        for (int w = 0; w < 2; w++) begin
            if (rst[w]) begin
                in_dp[w] = 1'b0;
            end else begin
                if (in_dp[w]) begin
                    if (!o_ready[w]) begin
                        waits[w]++;
                        if (q_size(w) > 0) begin
                            mon_e = q_peek(w);
                            check_output($sformatf("wait_resp dut%0d", w), 32'(o_resp[w]), 32'(mon_e.err));
                        end
                    end else if (q_size(w) == 0) begin
                        note_fail($sformatf("unexpected_completion dut%0d", w));
                        in_dp[w] = 1'b0;
                    end else begin
                        mon_e = q_pop(w);
                        check_output($sformatf("resp dut%0d", w), 32'(o_resp[w]), 32'(mon_e.err));
                        check_output($sformatf("wait_cycles dut%0d", w), 32'(waits[w]), 32'(mon_e.waits));
                        if (mon_e.err)
                            check_output($sformatf("err_rdata dut%0d", w), o_rdata[w], 32'd0);
                        else if (mon_e.is_read)
                            check_output($sformatf("rdata dut%0d", w), o_rdata[w], mon_e.data);
                        last_done_cyc[w] = cyc;
                        in_dp[w] = 1'b0;
                    end
                end else begin
                    check_output($sformatf("idle_ready dut%0d", w), 32'(o_ready[w]), 32'd1);
                    check_output($sformatf("idle_resp dut%0d", w), 32'(o_resp[w]), 32'd0);
                end
                if (o_ready[w] && d_sel[w] && d_trans[w][1]) begin
                    in_dp[w] = 1'b1;
                    waits[w] = 0;
                end
            end
        end
    end

    task automatic drive_directed_fast();
        apply_stimulus(0, 1, T_NONSEQ, 1, 3'd2, 32'h10, 32'hDEAD_BEEF, 3'd0);
        apply_stimulus(0, 1, T_NONSEQ, 0, 3'd2, 32'h10, 32'h0, 3'd0);
        apply_stimulus(0, 1, T_NONSEQ, 1, 3'd2, 32'h10, 32'h1122_3344, 3'd0);
        apply_stimulus(0, 1, T_NONSEQ, 1, 3'd0, 32'h13, 32'hA5A5_A5A5, 3'd0);
        apply_stimulus(0, 1, T_NONSEQ, 0, 3'd2, 32'h10, 32'h0, 3'd0);
        apply_stimulus(0, 1, T_NONSEQ, 1, 3'd1, 32'h12, 32'h5A5A_5A5A, 3'd0);
        apply_stimulus(0, 1, T_NONSEQ, 0, 3'd2, 32'h10, 32'h0, 3'd0);
        apply_stimulus(0, 1, T_NONSEQ, 0, 3'd2, 32'h1002, 32'h0, 3'd0);
        apply_stimulus(0, 1, T_NONSEQ, 0, 3'd2, 32'(4 * MEM_DEPTH), 32'h0, 3'd0);
        apply_stimulus(0, 1, T_NONSEQ, 0, 3'd2, 32'h10, 32'h0, 3'd0);
        apply_stimulus(0, 1, T_NONSEQ, 1, 3'd2, 32'h1002, 32'hFFFF_FFFF, 3'd0);
        apply_stimulus(0, 1, T_NONSEQ, 0, 3'd2, 32'h1000, 32'h0, 3'd0);
        set_idle(0);
        wait_drain(0);
    endtask

    task automatic drive_directed_slow();
        int c0;
        bit ok;
        apply_stimulus(1, 1, T_NONSEQ, 0, 3'd2, 32'h20, 32'h0, 3'b011);
        c0 = cyc;
        apply_stimulus(1, 1, T_SEQ, 0, 3'd2, 32'h24, 32'h0, 3'b011);
        apply_stimulus(1, 1, T_SEQ, 0, 3'd2, 32'h28, 32'h0, 3'b011);
        apply_stimulus(1, 1, T_SEQ, 0, 3'd2, 32'h2C, 32'h0, 3'b011);
        set_idle(1);
        wait_drain(1);
        check_output("incr4_cycles", 32'(last_done_cyc[1] - c0 + 1), 32'd16);

        d_sel[1]   = 1'b1;
        d_trans[1] = T_NONSEQ;
        d_write[1] = 1'b1;
        d_size[1]  = 3'd2;
        d_addr[1]  = 32'h40;
        wait_accept(1, ok);
        d_wdata[1] = 32'hCAFE_F00D;
        set_idle(1);
        @(posedge clk);
        #2;
        rst[1] = 1'b1;
        #1;
        check_output("rst_mid_ready", 32'(o_ready[1]), 32'd1);
        check_output("rst_mid_resp", 32'(o_resp[1]), 32'd0);
        check_output("rst_mid_rdata", o_rdata[1], 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        apply_stimulus(1, 1, T_NONSEQ, 0, 3'd2, 32'h40, 32'h0, 3'd0);
        set_idle(1);
        wait_drain(1);
    endtask

    task automatic drive(int w);
        logic [31:0] bad_addr [4];
        logic [31:0] addr;
        logic [2:0]  size;
        int          kind;
        bad_addr = '{32'h0000_1000, 32'h0000_1002, 32'hFFFF_FFFC, 32'h0000_2000};
        for (int i = 0; i < WIN_BYTES / 4; i++)
            apply_stimulus(w, 1, T_NONSEQ, 1, 3'd2, 32'(i * 4), $urandom, 3'd0);
        if (w == 0) drive_directed_fast();
        else        drive_directed_slow();
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
                apply_stimulus(w, 1, ($urandom_range(0, 1) == 0) ? T_IDLE : T_BUSY, 0, 3'd2, 32'h0, 32'h0, 3'd0);
            end else if (kind == 1) begin
                apply_stimulus(w, 0, T_NONSEQ, 1, 3'd2, 32'h8, $urandom, 3'd0);
            end else begin
                size = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
                if ($urandom_range(0, 9) == 0) begin
                    addr = bad_addr[$urandom_range(0, 3)];
                end else begin
                    addr = 32'($urandom_range(0, WIN_BYTES - 1));
                    if ((size <= 3'd2) && ($urandom_range(0, 3) != 0))
                        addr = addr & ~((32'd1 << size) - 32'd1);
                end
                apply_stimulus(w, 1, ($urandom_range(0, 1) == 0) ? T_NONSEQ : T_SEQ,
                               1'($urandom_range(0, 1)), size, addr, $urandom, 3'($urandom_range(0, 7)));
            end
        end
        set_idle(w);
        wait_drain(w);
    endtask

    initial begin
        for (int w = 0; w < 2; w++) begin
            rst[w]     = 1'b1;
            d_sel[w]   = 1'b0;
            d_addr[w]  = 32'h0;
            d_write[w] = 1'b0;
            d_size[w]  = 3'd0;
            d_burst[w] = 3'd0;
            d_trans[w] = T_IDLE;
            d_wdata[w] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            for (int w = 0; w < 2; w++) begin
                check_output($sformatf("reset_ready dut%0d", w), 32'(o_ready[w]), 32'd1);
                check_output($sformatf("reset_resp dut%0d", w), 32'(o_resp[w]), 32'd0);
                check_output($sformatf("reset_rdata dut%0d", w), o_rdata[w], 32'd0);
            end
        end
        @(posedge clk);
        #1;
        fork
            drive(0);
            drive(1);
        join
        repeat (4) @(posedge clk);
        check_output("final_queue dut0", 32'(q_size(0)), 32'd0);
        check_output("final_queue dut1", 32'(q_size(1)), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
